pic_rw_decoder: RTL
===================

# pic_rw_decoder

Bus-interface front end of the PIC-8259. It synchronizes the CPU strobes (CS_n, WR_n, RD_n, A0) and data bus into the clock domain and tracks the ICW1→ICW2→[ICW3]→[ICW4] initialization sequence. Each completed write is classified as one of ICW1..ICW4 or OCW1..OCW3 and presented to the control logic as a one-cycle command code plus data byte. It also produces the read-select code that picks IMR, IRR or ISR for the data buffer.

## Interface
- SYNC_STAGES, 2: synchronizer depth on CS_n, WR_n, RD_n, A0, D; legal range 2..3.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- cs_n  in  1  chip select, active-low.
- wr_n  in  1  write strobe, active-low; a write completes on its rising edge.
- rd_n  in  1  read strobe, active-low.
- a0  in  1  address bit.
- data_in  in  8  CPU data bus.
- write_flag  out  3  command code: 0 ICW1, 1 ICW2, 2 ICW3, 3 ICW4, 4 OCW1, 5 OCW2, 6 OCW3, 7 none.
- write_data  out  8  byte belonging to write_flag; held until the next accepted write.
- read_select  out  3  000 none, 011 IMR, 001 IRR, 101 ISR.
- data_oe  out  1  data buffer drive enable; high exactly when read_select≠000.
- init_done  out  1  initialization sequence complete.

## Operation
- Reset values: write_flag=7, write_data=0, read_select=000, data_oe=0, init_done=0, state=UNINIT, sngl=1, ic4=0, read register select=IRR.
- Synchronizer: all five inputs go through SYNC_STAGES flops, so they stay mutually aligned. Edge detection uses one further register on synced wr_n.
- Capture: on every cycle where synced wr_n=0 and cs_n=0, latch a0 and D into a capture register and set cap_valid. If synced rd_n=0 in the same cycle, set cap_err.
- Accept: on a synced wr_n 0→1 transition with cap_valid=1 and cap_err=0, classify the capture. Clear cap_valid and cap_err on every wr_n rising edge.
- Classification:
  - a0=0 and D[4]=1 → ICW1 in any state. Latch sngl=D[1] and ic4=D[0], clear init_done, go to WAIT_ICW2.
  - WAIT_ICW2, a0=1 → ICW2. Next state: WAIT_ICW3 if sngl=0; else WAIT_ICW4 if ic4=1; else READY.
  - WAIT_ICW3, a0=1 → ICW3. Next state: WAIT_ICW4 if ic4=1, else READY.
  - WAIT_ICW4, a0=1 → ICW4. Next state: READY.
  - READY, a0=1 → OCW1. READY, a0=0, D[4:3]=00 → OCW2. READY, a0=0, D[4:3]=01 → OCW3; latch read register select from D[1:0]: 10 IRR, 11 ISR, 0x unchanged.
  - Any other combination (UNINIT non-ICW1, a0=0 with D[4]=0 during WAIT_*) → ignored. No flag, state unchanged.
- init_done is set on entry to READY.
- Read: when synced cs_n=0 and rd_n=0 and wr_n=1:
  - a0=1 → read_select=011.
  - a0=0 → 001 or 101 per the latched read register select.
  - Otherwise read_select=000.
  - Reads are honored in every state.
- RD and WR low together: no read_select, and the write is discarded.

## Timing
- Write latency: let clock edge k be the first to sample pin wr_n high. With SYNC_STAGES=2, write_flag/write_data are valid after edge k+2. write_flag returns to 7 after edge k+3 (exactly one cycle). write_data holds.
- Read latency: read_select/data_oe assert after edge k+2, where k first samples rd_n (or cs_n) active. They deassert with the same latency.
- Strobe pulses shorter than one clock period are not guaranteed to be seen. Back-to-back writes need wr_n high for ≥2 clocks.
- reset asserted mid-write or mid-sequence: outputs go to reset values immediately (asynchronously). The in-flight write is lost, and state returns to UNINIT.
- An OCW3 read-select change applies to reads whose synced rd_n falls after the OCW3 flag cycle.

## Test plan
- Reset, then ICW1=0x13 (sngl=1, ic4=1), ICW2=0x20, ICW4=0x01 → flags 0, 1, 3 in order, each one cycle wide. ICW3 is skipped and init_done=1 after the ICW4 flag.
- ICW1=0x10 (cascade, no ICW4), ICW2=0x08, ICW3=0x04 → flags 0, 1, 2, then READY. The next a0=1 write of 0xFE gives flag 4 with write_data=0xFE.
- In READY: a0=0 write 0x20 → flag 5. Then a0=0 write 0x0B → flag 6. A following read with a0=0 → read_select=101 and data_oe=1. After OCW3=0x0A, read_select=001.
- Write a0=1 0x55 after reset, before any ICW1 → write_flag stays 7. A read with a0=1 still gives read_select=011.
- rd_n and wr_n low together with cs_n=0 → read_select=000 and no flag on the wr_n rise. Separately, a write with cs_n=1 → no flag.
- Assert reset during WAIT_ICW3 → init_done=0 and write_flag=7 immediately. A subsequent a0=1 write gives no flag until a new ICW1.

Source files
------------

// File: rtl/pic_rw_decoder.sv
// PIC-8259 bus-interface front end: synchronizes the CPU strobes and data bus,
// tracks the ICW initialization sequence, and classifies every completed write.
module pic_rw_decoder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       a0,
  input  logic [7:0] data_in,
  output logic [2:0] write_flag,
  output logic [7:0] write_data,
  output logic [2:0] read_select,
  output logic       data_oe,
  output logic       init_done
);

  typedef enum logic [2:0] {
    UNINIT,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } state_e;

  localparam logic [2:0] FLAG_ICW1 = 3'd0;
  localparam logic [2:0] FLAG_ICW2 = 3'd1;
  localparam logic [2:0] FLAG_ICW3 = 3'd2;
  localparam logic [2:0] FLAG_ICW4 = 3'd3;
  localparam logic [2:0] FLAG_OCW1 = 3'd4;
  localparam logic [2:0] FLAG_OCW2 = 3'd5;
  localparam logic [2:0] FLAG_OCW3 = 3'd6;
  localparam logic [2:0] FLAG_NONE = 3'd7;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_IMR  = 3'b011;
  localparam logic [2:0] SEL_IRR  = 3'b001;
  localparam logic [2:0] SEL_ISR  = 3'b101;

  // Bundle order {cs_n, wr_n, rd_n, a0, data}; reset to an idle bus so no false edge appears.
  localparam logic [11:0] SYNC_IDLE = 12'hE00;

  logic [11:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
    end else begin
      sync_q[0] <= {cs_n, wr_n, rd_n, a0, data_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic       csS, wrS, rdS, a0S;
  logic [7:0] dS;
  assign {csS, wrS, rdS, a0S, dS} = sync_q[SYNC_STAGES-1];

  logic       wrPrev_q;
  logic       capValid_q, capErr_q, capA0_q;
  logic [7:0] capData_q;
  logic       wrRise, accept;

  assign wrRise = wrS & ~wrPrev_q;
  assign accept = wrRise & capValid_q & ~capErr_q;

  // Capture register tracks the last low-strobe cycle; a read overlapping the write poisons it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPrev_q   <= 1'b1;
      capValid_q <= 1'b0;
      capErr_q   <= 1'b0;
      capA0_q    <= 1'b0;
      capData_q  <= 8'h00;
    end else begin
      wrPrev_q <= wrS;
      if (wrRise) begin
        capValid_q <= 1'b0;
        capErr_q   <= 1'b0;
      end else if (!wrS && !csS) begin
        capValid_q <= 1'b1;
        capA0_q    <= a0S;
        capData_q  <= dS;
        if (!rdS) capErr_q <= 1'b1;
      end
    end
  end

  state_e     state_q, state_d;
  logic [2:0] writeFlag_q, writeFlag_d;
  logic [7:0] writeData_q, writeData_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic       initDone_q, initDone_d;
  logic       rrIsr_q, rrIsr_d;
  logic [2:0] readSel_q, readSel_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= UNINIT;
      writeFlag_q <= FLAG_NONE;
      writeData_q <= 8'h00;
      sngl_q      <= 1'b1;
      ic4_q       <= 1'b0;
      initDone_q  <= 1'b0;
      rrIsr_q     <= 1'b0;
      readSel_q   <= SEL_NONE;
    end else begin
      state_q     <= state_d;
      writeFlag_q <= writeFlag_d;
      writeData_q <= writeData_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      initDone_q  <= initDone_d;
      rrIsr_q     <= rrIsr_d;
      readSel_q   <= readSel_d;
    end
  end

  // ICW1 restarts the sequence from any state; other writes depend on where we are.
  always_comb begin
    state_d     = state_q;
    writeFlag_d = FLAG_NONE;
    writeData_d = writeData_q;
    sngl_d      = sngl_q;
    ic4_d       = ic4_q;
    initDone_d  = initDone_q;
    rrIsr_d     = rrIsr_q;
    if (accept) begin
      if (!capA0_q && capData_q[4]) begin
        writeFlag_d = FLAG_ICW1;
        writeData_d = capData_q;
        sngl_d      = capData_q[1];
        ic4_d       = capData_q[0];
        initDone_d  = 1'b0;
        state_d     = WAIT_ICW2;
      end else begin
        case (state_q)
          WAIT_ICW2: if (capA0_q) begin
            writeFlag_d = FLAG_ICW2;
            writeData_d = capData_q;
            if (!sngl_q) begin
              state_d = WAIT_ICW3;
            end else if (ic4_q) begin
              state_d = WAIT_ICW4;
            end else begin
              state_d    = READY;
              initDone_d = 1'b1;
            end
          end
          WAIT_ICW3: if (capA0_q) begin
            writeFlag_d = FLAG_ICW3;
            writeData_d = capData_q;
            if (ic4_q) begin
              state_d = WAIT_ICW4;
            end else begin
              state_d    = READY;
              initDone_d = 1'b1;
            end
          end
          WAIT_ICW4: if (capA0_q) begin
            writeFlag_d = FLAG_ICW4;
            writeData_d = capData_q;
            state_d     = READY;
            initDone_d  = 1'b1;
          end
          READY: begin
            if (capA0_q) begin
              writeFlag_d = FLAG_OCW1;
              writeData_d = capData_q;
            end else if (capData_q[4:3] == 2'b00) begin
              writeFlag_d = FLAG_OCW2;
              writeData_d = capData_q;
            end else if (capData_q[4:3] == 2'b01) begin
              writeFlag_d = FLAG_OCW3;
              writeData_d = capData_q;
              if (capData_q[1:0] == 2'b10) rrIsr_d = 1'b0;
              else if (capData_q[1:0] == 2'b11) rrIsr_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    readSel_d = SEL_NONE;
    if (!csS && !rdS && wrS) readSel_d = a0S ? SEL_IMR : (rrIsr_q ? SEL_ISR : SEL_IRR);
  end

  assign write_flag  = writeFlag_q;
  assign write_data  = writeData_q;
  assign read_select = readSel_q;
  assign data_oe     = (readSel_q != SEL_NONE);
  assign init_done   = initDone_q;

endmodule
